// File: rtl/gen_timer_if.sv
// -----------------------------------------------------------------------------
// gen_timer_if
//
// Purpose:
//   Bundles the control and status signals of gen_timer so that the timer and
//   its users (delay, pulse-stretch and debounce blocks) connect through one
//   port. Clock and resets stay outside the bundle as plain ports.
//
// Parameters:
//   WIDTH       width of the terminal value and of the counter
//
// Signals (direction as seen by the timer, i.e. the slave modport):
//   cnt_en_in    in   1      count enable; gates steps
//   start_in     in   1      start/restart request, level-sampled each edge
//   mode_in      in   2      00 one-shot, 01 retrigger, 10 periodic, 11 one-shot
//   load_val_in  in   WIDTH  terminal count, latched at start
//   count_out    out  WIDTH  current count
//   busy_out     out  1      high while running
//   done_out     out  1      high once a one-shot/retrigger run has finished
//   expire_out   out  1      one-cycle terminal-count strobe
//   step_out     out  1      high in cycles where the count advances
//   state_dbg    out  2      FSM state (0 idle, 1 run, 2 done) for observation
//
// Request protocol:
//   There is no ready/acknowledge. start_in is a level sampled on every rising
//   clock edge; a start is accepted on any edge where the timer is idle or
//   done, or (retrigger mode only) while running. mode_in and load_val_in only
//   matter on the edge where a start is accepted.
// -----------------------------------------------------------------------------
interface gen_timer_if #(
    parameter int WIDTH = 16
);
    logic             cnt_en_in;
    logic             start_in;
    logic [1:0]       mode_in;
    logic [WIDTH-1:0] load_val_in;
    logic [WIDTH-1:0] count_out;
    logic             busy_out;
    logic             done_out;
    logic             expire_out;
    logic             step_out;
    logic [1:0]       state_dbg;

    // Side that drives the timer (the block using the interval).
    modport master (
        output cnt_en_in,
        output start_in,
        output mode_in,
        output load_val_in,
        input  count_out,
        input  busy_out,
        input  done_out,
        input  expire_out,
        input  step_out,
        input  state_dbg
    );

    // The timer itself.
    modport slave (
        input  cnt_en_in,
        input  start_in,
        input  mode_in,
        input  load_val_in,
        output count_out,
        output busy_out,
        output done_out,
        output expire_out,
        output step_out,
        output state_dbg
    );
endinterface

// File: rtl/gen_timer.sv
// -----------------------------------------------------------------------------
// gen_timer
//
// Purpose:
//   Mode-selectable interval timer for power sequencing. A start latches a
//   terminal count N and a mode, then the counter steps from 0 up to N on
//   qualified enable cycles. On reaching N a one-cycle expire strobe is
//   raised; the timer then finishes (one-shot, retrigger) or reloads to 0 and
//   keeps running (periodic). Retrigger mode accepts a fresh start while
//   running.
//
// Parameters:
//   WIDTH     width of terminal value and counter (default 16)
//   PRESCALE  clock-enable divide ratio 1..65535 (default 1); only has an
//             effect when the prescaler is compiled in
//
// Ports:
//   clk_in         in   clock
//   rst_L_in       in   asynchronous active-low reset
//   rst_sync_L_in  in   synchronous active-low abort, dominates all inputs
//   tmr            gen_timer_if.slave bundle (enable, start, mode, load
//                  value in; count, busy, done, expire, step, state out)
//
// Build option:
//   GEN_TIMER_PRESCALE_EN  when defined, a prescaler counter divides the
//                          enable so that one step occurs every PRESCALE
//                          enabled cycles. When undefined no prescaler logic
//                          exists and every enabled cycle in RUN is a step.
//
// Timing (enable held high, ratio P, terminal N, start sampled at edge k):
//   count = 0 after edge k, count = N after edge k+N*P, expire_out high in the
//   following cycle, DONE or periodic reload at edge k+N*P+1.
// -----------------------------------------------------------------------------
module gen_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic        clk_in,
    input  logic        rst_L_in,
    input  logic        rst_sync_L_in,
    gen_timer_if.slave  tmr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RETRIG   = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;

    // Reject an out-of-range ratio at elaboration in every build.
    if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
        $error("gen_timer: PRESCALE must be in 1..65535");
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_term;
    logic [1:0]       r_mode;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_term_nxt;
    logic [1:0]       w_mode_nxt;

    logic             w_run;
    logic             w_expire;
    logic             w_tick;
    logic             w_step;
    logic             w_restart;

`ifdef GEN_TIMER_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;

    // Tick on the last prescaler value; the counter wraps to 0 right after.
    assign w_tick = (r_pre == PRE_LAST);
`else
    assign w_tick = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Decodes from registers
    // -------------------------------------------------------------------------
    assign w_run    = (r_state == ST_RUN);
    // expire and step are mutually exclusive: a step needs count != term.
    assign w_expire = w_run && (r_count == r_term);
    assign w_step   = w_run && tmr.cnt_en_in && w_tick && !w_expire;
    // Only a latched retrigger mode turns start into a restart while running.
    assign w_restart = w_run && tmr.start_in && (r_mode == MODE_RETRIG);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_L_in) begin
        if (!rst_L_in) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_term  <= '0;
            r_mode  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_term  <= w_term_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

`ifdef GEN_TIMER_PRESCALE_EN
    always_ff @(posedge clk_in or negedge rst_L_in) begin
        if (!rst_L_in) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_pre_nxt;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_term_nxt  = r_term;
        w_mode_nxt  = r_mode;
`ifdef GEN_TIMER_PRESCALE_EN
        w_pre_nxt   = r_pre;
`endif

        if (!rst_sync_L_in) begin
            // Synchronous abort looks exactly like a reset and beats start.
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_term_nxt  = '0;
            w_mode_nxt  = '0;
`ifdef GEN_TIMER_PRESCALE_EN
            w_pre_nxt   = '0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (tmr.start_in) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = '0;
                        w_term_nxt  = tmr.load_val_in;
                        w_mode_nxt  = tmr.mode_in;
`ifdef GEN_TIMER_PRESCALE_EN
                        w_pre_nxt   = '0;
`endif
                    end
                end

                ST_RUN: begin
                    if (w_restart) begin
                        // Restart wins over a coincident expiry.
                        w_count_nxt = '0;
                        w_term_nxt  = tmr.load_val_in;
                        w_mode_nxt  = tmr.mode_in;
`ifdef GEN_TIMER_PRESCALE_EN
                        w_pre_nxt   = '0;
`endif
                    end else if (tmr.cnt_en_in) begin
                        // With the enable low everything in RUN is frozen.
                        if (w_expire) begin
                            if (r_mode == MODE_PERIODIC) begin
                                w_count_nxt = '0;
`ifdef GEN_TIMER_PRESCALE_EN
                                w_pre_nxt   = '0;
`endif
                            end else begin
                                // One-shot, retrigger and mode 11 finish here;
                                // count already equals term and is held.
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
`ifdef GEN_TIMER_PRESCALE_EN
                            if (w_tick) begin
                                w_pre_nxt = '0;
                            end else begin
                                w_pre_nxt = r_pre + PRE_W'(1);
                            end
`endif
                            if (w_step) begin
                                // count < term here, so this cannot wrap.
                                w_count_nxt = r_count + WIDTH'(1);
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_term_nxt  = '0;
                    w_mode_nxt  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tmr.count_out  = r_count;
    assign tmr.busy_out   = w_run;
    assign tmr.done_out   = (r_state == ST_DONE);
    assign tmr.expire_out = w_expire;
    assign tmr.step_out   = w_step;
    assign tmr.state_dbg  = r_state;

endmodule

// File: tb/tb_gen_timer.sv
// -----------------------------------------------------------------------------
// tb_gen_timer
//
// Directed bench for gen_timer: one-shot, periodic, retrigger (including
// restart coinciding with expiry), enable gating, zero terminal, mode 11,
// synchronous abort and asynchronous reset. The prescaled periodic sequence
// runs only when GEN_TIMER_PRESCALE_EN is defined (PRESCALE = 4 here).
// Inputs are driven just after the falling edge and outputs are checked there,
// well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_gen_timer;

    localparam int WIDTH = 16;

    logic clk_in;
    logic rst_L_in;
    logic rst_sync_L_in;

    int checks = 0;
    int errors = 0;

    gen_timer_if #(.WIDTH(WIDTH)) bus ();

    gen_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_L_in      (rst_L_in),
        .rst_sync_L_in (rst_sync_L_in),
        .tmr           (bus.slave)
    );

    // ---------------------------------------------------------------- clock
    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    // ---------------------------------------------------------------- tasks
    // Advance over one rising edge and stop just after the falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge, then scramble mode/load to prove latching.
    task automatic do_start(input logic [1:0] m, input logic [15:0] v);
        bus.start_in    = 1'b1;
        bus.mode_in     = m;
        bus.load_val_in = v;
        tick();
        bus.start_in    = 1'b0;
        bus.mode_in     = 2'b10;
        bus.load_val_in = 16'hBEEF;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_L_in        = 1'b0;
        rst_sync_L_in   = 1'b1;
        bus.cnt_en_in   = 1'b0;
        bus.start_in    = 1'b0;
        bus.mode_in     = 2'b00;
        bus.load_val_in = '0;

        // Reset state
        tick();
        tick();
        chk("rst_count",  bus.count_out,  0);
        chk("rst_busy",   bus.busy_out,   0);
        chk("rst_done",   bus.done_out,   0);
        chk("rst_expire", bus.expire_out, 0);
        chk("rst_step",   bus.step_out,   0);
        chk("rst_state",  bus.state_dbg,  0);
        rst_L_in      = 1'b1;
        bus.cnt_en_in = 1'b1;
        tick();
        chk("idle_state", bus.state_dbg, 0);

        // One-shot, N=5
        do_start(2'b00, 16'd5);
        chk("os_count0", bus.count_out, 0);
        chk("os_busy",   bus.busy_out,  1);
        chk("os_step0",  bus.step_out,  1);
        chk("os_state",  bus.state_dbg, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("os_count",  bus.count_out,  i);
            chk("os_expire", bus.expire_out, (i == 5) ? 1 : 0);
            chk("os_step",   bus.step_out,   (i < 5) ? 1 : 0);
        end
        tick();
        chk("os_done",       bus.done_out,   1);
        chk("os_busy_off",   bus.busy_out,   0);
        chk("os_count_hold", bus.count_out,  5);
        chk("os_expire_off", bus.expire_out, 0);
        chk("os_state_done", bus.state_dbg,  2);
        tick();
        chk("os_count_hold2", bus.count_out, 5);

        // Periodic, N=3: expire every 4 cycles, count 0,1,2,3,0...
        do_start(2'b10, 16'd3);
        chk("per_count0", bus.count_out, 0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("per_count",  bus.count_out,  j % 4);
            chk("per_expire", bus.expire_out, ((j % 4) == 3) ? 1 : 0);
            chk("per_done",   bus.done_out,   0);
        end
        // Start is ignored in periodic mode; counting just continues.
        do_start(2'b00, 16'd9);
        chk("per_ign_count", bus.count_out, 1);
        chk("per_ign_busy",  bus.busy_out,  1);

        // Asynchronous reset mid-run clears without a clock edge.
        rst_L_in = 1'b0;
        #1;
        chk("arst_count",  bus.count_out,  0);
        chk("arst_busy",   bus.busy_out,   0);
        chk("arst_expire", bus.expire_out, 0);
        chk("arst_step",   bus.step_out,   0);
        rst_L_in = 1'b1;
        tick();
        chk("arst_state", bus.state_dbg, 0);

        // Retrigger, N=10, restart at count=6
        do_start(2'b01, 16'd10);
        for (int i = 1; i <= 6; i++) tick();
        chk("rt_count6", bus.count_out, 6);
        do_start(2'b01, 16'd10);
        chk("rt_restart_count", bus.count_out, 0);
        chk("rt_restart_busy",  bus.busy_out,  1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            chk("rt_expire", bus.expire_out, (j == 10) ? 1 : 0);
        end
        chk("rt_count10", bus.count_out, 10);
        tick();
        chk("rt_done",      bus.done_out,  1);
        chk("rt_done_hold", bus.count_out, 10);

        // Retrigger: restart coincides with expiry and wins
        do_start(2'b01, 16'd2);
        tick();
        tick();
        chk("rtx_expire", bus.expire_out, 1);
        bus.start_in = 1'b1;
        #1;
        chk("rtx_expire_seen", bus.expire_out, 1);
        do_start(2'b01, 16'd3);
        chk("rtx_count0", bus.count_out, 0);
        chk("rtx_busy",   bus.busy_out,  1);
        chk("rtx_done",   bus.done_out,  0);
        tick();
        tick();
        tick();
        chk("rtx_expire3", bus.expire_out, 1);
        chk("rtx_count3",  bus.count_out,  3);
        tick();
        chk("rtx_done_end", bus.done_out, 1);

        // Enable gating, N=4: enable low on even cycles, 4 steps take 8 cycles
        do_start(2'b00, 16'd4);
        for (int c = 0; c < 8; c++) begin
            bus.cnt_en_in = c[0];
            #1;
            chk("gate_count", bus.count_out, c / 2);
            chk("gate_step",  bus.step_out,  c % 2);
            tick();
        end
        bus.cnt_en_in = 1'b1;
        #1;
        chk("gate_count4", bus.count_out,  4);
        chk("gate_expire", bus.expire_out, 1);
        chk("gate_step4",  bus.step_out,   0);
        tick();
        chk("gate_done", bus.done_out, 1);

        // Terminal count 0: expire right after the start edge
        do_start(2'b00, 16'd0);
        chk("z_expire", bus.expire_out, 1);
        chk("z_count",  bus.count_out,  0);
        chk("z_busy",   bus.busy_out,   1);
        chk("z_step",   bus.step_out,   0);
        tick();
        chk("z_done",       bus.done_out,   1);
        chk("z_expire_off", bus.expire_out, 0);

        // Mode 11 behaves as one-shot
        do_start(2'b11, 16'd2);
        tick();
        tick();
        chk("m3_expire", bus.expire_out, 1);
        tick();
        chk("m3_done",  bus.done_out,  1);
        chk("m3_count", bus.count_out, 2);
        chk("m3_state", bus.state_dbg, 2);

        // Synchronous abort at count=7 with a simultaneous start
        do_start(2'b00, 16'd20);
        for (int i = 1; i <= 7; i++) tick();
        chk("ab_count7", bus.count_out, 7);
        rst_sync_L_in   = 1'b0;
        bus.start_in    = 1'b1;
        bus.mode_in     = 2'b00;
        bus.load_val_in = 16'd5;
        tick();
        chk("ab_count",  bus.count_out,  0);
        chk("ab_busy",   bus.busy_out,   0);
        chk("ab_done",   bus.done_out,   0);
        chk("ab_expire", bus.expire_out, 0);
        chk("ab_step",   bus.step_out,   0);
        rst_sync_L_in = 1'b1;
        bus.start_in  = 1'b0;
        tick();
        chk("ab_idle", bus.state_dbg, 0);

`ifdef GEN_TIMER_PRESCALE_EN
        // Prescaled periodic, P=4, N=3: step every 4th cycle, period 13
        do_start(2'b10, 16'd3);
        for (int c = 0; c < 26; c++) begin
            chk("ps_step",   bus.step_out,   (((c % 13) % 4) == 3 && (c % 13) != 12) ? 1 : 0);
            chk("ps_expire", bus.expire_out, ((c % 13) == 12) ? 1 : 0);
            chk("ps_count",  bus.count_out,  (c % 13) / 4);
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
